// File: rtl/decode_stage_if.sv
// decode_stage_if -- fetch-side and execute-side handshake bundle for the
// LEGv8 decode stage.
//   in_valid/in_ready/in_instr : instruction word offered by fetch
//   out_valid/out_ready        : decoded bundle offered to execute
//   out_*                      : registered datapath controls and fields
// Modports: slave = decode stage view, master = fetch/execute (bench) view.
interface decode_stage_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic              out_reg2loc;
  logic              out_uncondbranch;
  logic              out_branch;
  logic              out_memread;
  logic              out_memtoreg;
  logic              out_memwrite;
  logic              out_alusrc;
  logic              out_regwrite;
  logic [3:0]        out_alu_ctrl;
  logic [4:0]        out_rn;
  logic [4:0]        out_rm;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_imm;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid,
    output out_reg2loc, out_uncondbranch, out_branch, out_memread,
    output out_memtoreg, out_memwrite, out_alusrc, out_regwrite,
    output out_alu_ctrl, out_rn, out_rm, out_rd, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid,
    input  out_reg2loc, out_uncondbranch, out_branch, out_memread,
    input  out_memtoreg, out_memwrite, out_alusrc, out_regwrite,
    input  out_alu_ctrl, out_rn, out_rm, out_rd, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage -- one-cycle LEGv8 instruction decode with valid/ready
// handshakes on both sides and load-use bubble insertion.
//   clk       : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous flush, drops the output and the pending load tag
//   bus       : decode_stage_if.slave (fetch input, execute output)
//   stall_cnt : saturating count of inserted load-use bubbles
module decode_stage #(
  parameter int DATA_W    = 64,
  parameter int HAZARD_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus,
  output logic [15:0]   stall_cnt
);

  // Control vector bit positions
  localparam int C_REG2LOC = 7;
  localparam int C_UNCOND  = 6;
  localparam int C_BRANCH  = 5;
  localparam int C_MEMREAD = 4;
  localparam int C_MEMTOREG= 3;
  localparam int C_MEMWRITE= 2;
  localparam int C_ALUSRC  = 1;
  localparam int C_REGWRITE= 0;

  logic [31:0] instr;
  assign instr = bus.in_instr;

  // ---------------- combinational decode ----------------
  logic [7:0]  ctrl_next;
  logic [3:0]  alu_next;
  logic [4:0]  rd_next;
  logic [63:0] imm64;
  logic        illegal_next;
  logic        uses_rn, uses_rm, uses_rt, is_ldur;

  always_comb begin
    ctrl_next    = '0;
    alu_next     = 4'b0000;
    rd_next      = instr[4:0];
    imm64        = '0;
    illegal_next = 1'b0;
    uses_rn      = 1'b0;
    uses_rm      = 1'b0;
    uses_rt      = 1'b0;
    is_ldur      = 1'b0;

    if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      // B / BL
      ctrl_next[C_UNCOND] = 1'b1;
      imm64 = {{38{instr[25]}}, instr[25:0]};
      if (instr[31]) begin
        rd_next               = 5'd30;
        ctrl_next[C_REGWRITE] = 1'b1;
      end
    end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101) begin
      // CBZ / CBNZ
      ctrl_next[C_REG2LOC] = 1'b1;
      ctrl_next[C_BRANCH]  = 1'b1;
      alu_next = instr[24] ? 4'b0001 : 4'b0111;
      imm64    = {{45{instr[23]}}, instr[23:5]};
      uses_rn  = 1'b1;
      uses_rt  = 1'b1;
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100 ||
                 instr[31:22] == 10'b1001001000 || instr[31:22] == 10'b1011001000 ||
                 instr[31:22] == 10'b1101001000) begin
      // I-type arithmetic / logic
      ctrl_next[C_ALUSRC]   = 1'b1;
      ctrl_next[C_REGWRITE] = 1'b1;
      imm64   = {52'd0, instr[21:10]};
      uses_rn = 1'b1;
      case (instr[31:22])
        10'b1001000100: alu_next = 4'b0010;
        10'b1101000100: alu_next = 4'b1010;
        10'b1001001000: alu_next = 4'b0110;
        10'b1011001000: alu_next = 4'b0100;
        default:        alu_next = 4'b1001;
      endcase
    end else if (instr[31:23] == 9'b110100101) begin
      // MOVZ: a 32-bit datapath cannot hold shifts of 32 or 48
      if (DATA_W == 32 && instr[22]) begin
        illegal_next = 1'b1;
      end else begin
        ctrl_next[C_ALUSRC]   = 1'b1;
        ctrl_next[C_REGWRITE] = 1'b1;
        alu_next = 4'b1101;
        imm64    = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
      end
    end else if (instr[31:21] == 11'b10001011000 || instr[31:21] == 11'b11001011000 ||
                 instr[31:21] == 11'b10001010000 || instr[31:21] == 11'b10101010000 ||
                 instr[31:21] == 11'b11001010000) begin
      // R-type
      ctrl_next[C_REGWRITE] = 1'b1;
      uses_rn = 1'b1;
      uses_rm = 1'b1;
      case (instr[31:21])
        11'b10001011000: alu_next = 4'b0010;
        11'b11001011000: alu_next = 4'b1010;
        11'b10001010000: alu_next = 4'b0110;
        11'b10101010000: alu_next = 4'b0100;
        default:         alu_next = 4'b1001;
      endcase
    end else if (instr[31:21] == 11'b11111000010) begin
      // LDUR
      ctrl_next[C_MEMREAD]  = 1'b1;
      ctrl_next[C_MEMTOREG] = 1'b1;
      ctrl_next[C_ALUSRC]   = 1'b1;
      ctrl_next[C_REGWRITE] = 1'b1;
      alu_next = 4'b0010;
      imm64    = {{55{instr[20]}}, instr[20:12]};
      uses_rn  = 1'b1;
      is_ldur  = 1'b1;
    end else if (instr[31:21] == 11'b11111000000) begin
      // STUR
      ctrl_next[C_REG2LOC]  = 1'b1;
      ctrl_next[C_MEMWRITE] = 1'b1;
      ctrl_next[C_ALUSRC]   = 1'b1;
      alu_next = 4'b0010;
      imm64    = {{55{instr[20]}}, instr[20:12]};
      uses_rn  = 1'b1;
      uses_rt  = 1'b1;
    end else begin
      illegal_next = 1'b1;
    end
  end

  // ---------------- handshake and hazard ----------------
  logic        out_valid_reg;
  logic        ld_tag_v_reg;
  logic [4:0]  ld_tag_reg;
  logic [15:0] stall_cnt_reg;
  logic        adv, hazard, in_ready, transfer;

  // ld_tag_v is never set for X31, so a source field of 31 cannot match.
  assign hazard = (HAZARD_EN != 0) && ld_tag_v_reg && bus.in_valid &&
                  ((uses_rn && instr[9:5]   == ld_tag_reg) ||
                   (uses_rm && instr[20:16] == ld_tag_reg) ||
                   (uses_rt && instr[4:0]   == ld_tag_reg));

  assign adv      = !out_valid_reg || bus.out_ready;
  assign in_ready = rst_n && adv && !flush && !hazard;
  assign transfer = bus.in_valid && in_ready;

  // ---------------- output register ----------------
  logic [7:0]        ctrl_reg;
  logic [3:0]        alu_reg;
  logic [4:0]        rn_reg, rm_reg, rd_reg;
  logic [DATA_W-1:0] imm_reg;
  logic              illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      ld_tag_v_reg  <= 1'b0;
      ld_tag_reg    <= 5'd0;
      stall_cnt_reg <= 16'd0;
      ctrl_reg      <= '0;
      alu_reg       <= 4'd0;
      rn_reg        <= 5'd0;
      rm_reg        <= 5'd0;
      rd_reg        <= 5'd0;
      imm_reg       <= '0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      ld_tag_v_reg  <= 1'b0;
    end else if (adv) begin
      if (transfer) begin
        out_valid_reg <= 1'b1;
        ctrl_reg      <= ctrl_next;
        alu_reg       <= alu_next;
        rn_reg        <= instr[9:5];
        rm_reg        <= instr[20:16];
        rd_reg        <= rd_next;
        imm_reg       <= imm64[DATA_W-1:0];
        illegal_reg   <= illegal_next;
        ld_tag_reg    <= instr[4:0];
        ld_tag_v_reg  <= is_ldur && (instr[4:0] != 5'd31);
      end else begin
        // Empty slot or load-use bubble
        out_valid_reg <= 1'b0;
        ld_tag_v_reg  <= 1'b0;
        if (hazard && stall_cnt_reg != 16'hFFFF)
          stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = out_valid_reg;
  assign bus.out_reg2loc      = ctrl_reg[C_REG2LOC];
  assign bus.out_uncondbranch = ctrl_reg[C_UNCOND];
  assign bus.out_branch       = ctrl_reg[C_BRANCH];
  assign bus.out_memread      = ctrl_reg[C_MEMREAD];
  assign bus.out_memtoreg     = ctrl_reg[C_MEMTOREG];
  assign bus.out_memwrite     = ctrl_reg[C_MEMWRITE];
  assign bus.out_alusrc       = ctrl_reg[C_ALUSRC];
  assign bus.out_regwrite     = ctrl_reg[C_REGWRITE];
  assign bus.out_alu_ctrl     = alu_reg;
  assign bus.out_rn           = rn_reg;
  assign bus.out_rm           = rm_reg;
  assign bus.out_rd           = rd_reg;
  assign bus.out_imm          = imm_reg;
  assign bus.out_illegal      = illegal_reg;
  assign stall_cnt            = stall_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed vectors for decode_stage. Two instances share
// the same stimulus: dut (DATA_W=64, hazard detection on) and dut_nh
// (DATA_W=32, hazard detection off).
module tb_decode_stage;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;
  logic [15:0] stall_cnt, stall_cnt_nh;

  int tests_run    = 0;
  int tests_failed = 0;

  decode_stage_if #(.DATA_W(64)) bus    ();
  decode_stage_if #(.DATA_W(32)) bus_nh ();

  assign bus.in_valid     = in_valid;
  assign bus.in_instr     = in_instr;
  assign bus.out_ready    = out_ready;
  assign bus_nh.in_valid  = in_valid;
  assign bus_nh.in_instr  = in_instr;
  assign bus_nh.out_ready = out_ready;

  decode_stage #(.DATA_W(64), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  decode_stage #(.DATA_W(32), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_nh), .stall_cnt(stall_cnt_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ctrl_of_dut();
    return {bus.out_reg2loc, bus.out_uncondbranch, bus.out_branch, bus.out_memread,
            bus.out_memtoreg, bus.out_memwrite, bus.out_alusrc, bus.out_regwrite};
  endfunction

  // Back-to-back decode table: instr, controls, alu_ctrl, rd, imm, illegal
  logic [31:0] v_instr [6] = '{32'h00000000, 32'hD2E00020, 32'h91001441,
                               32'hF8008083, 32'hB4FFFFE2, 32'h97FFFFFE};
  logic [7:0]  v_ctrl  [6] = '{8'h00, 8'h03, 8'h03, 8'h86, 8'hA0, 8'h41};
  logic [3:0]  v_alu   [6] = '{4'h0, 4'hD, 4'h2, 4'h2, 4'h7, 4'h0};
  logic [4:0]  v_rd    [6] = '{5'd0, 5'd0, 5'd1, 5'd3, 5'd2, 5'd30};
  logic [63:0] v_imm   [6] = '{64'h0, 64'h0001_0000_0000_0000, 64'd5, 64'd8,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
  logic        v_ill   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h8B020023;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_regwrite",  bus.out_regwrite, 1'b0);
    check("rst_imm",       bus.out_imm, 64'd0);
    in_valid = 1'b0;
    #10 rst_n = 1'b1;
    step();

    // ADD X3,X1,X2
    in_valid = 1'b1;
    in_instr = 32'h8B020023;
    #1 check("add_in_ready", bus.in_ready, 1'b1);
    step();
    $display("[TB] ADD X3,X1,X2 issued");
    check("add_valid",    bus.out_valid, 1'b1);
    check("add_ctrl",     ctrl_of_dut(), 8'h01);
    check("add_alu",      bus.out_alu_ctrl, 4'b0010);
    check("add_rn",       bus.out_rn, 5'd1);
    check("add_rm",       bus.out_rm, 5'd2);
    check("add_rd",       bus.out_rd, 5'd3);
    check("add_imm",      bus.out_imm, 64'd0);
    in_valid = 1'b0;
    step();
    check("idle_valid", bus.out_valid, 1'b0);

    // LDUR X5,[X1,#-8] followed by dependent ADD X6,X5,X2
    in_valid = 1'b1;
    in_instr = 32'hF85F8025;
    step();
    $display("[TB] LDUR X5,[X1,#-8] issued");
    check("ldur_valid", bus.out_valid, 1'b1);
    check("ldur_ctrl",  ctrl_of_dut(), 8'h1B);
    check("ldur_imm",   bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_rd",    bus.out_rd, 5'd5);
    in_instr = 32'h8B0200A6;
    #1 check("hazard_in_ready", bus.in_ready, 1'b0);
    step();
    $display("[TB] ADD X6,X5,X2 stalled");
    check("bubble_valid",     bus.out_valid, 1'b0);
    check("bubble_stall_cnt", stall_cnt, 16'd1);
    check("nh_valid",         bus_nh.out_valid, 1'b1);
    check("nh_rd",            bus_nh.out_rd, 5'd6);
    check("nh_stall_cnt",     stall_cnt_nh, 16'd0);
    #1 check("after_bubble_in_ready", bus.in_ready, 1'b1);
    step();
    $display("[TB] ADD X6,X5,X2 issued");
    check("dep_add_valid", bus.out_valid, 1'b1);
    check("dep_add_rd",    bus.out_rd, 5'd6);
    check("dep_add_rn",    bus.out_rn, 5'd5);

    // LDUR X31 never creates a hazard
    in_instr = 32'hF85F803F;
    step();
    in_instr = 32'h8B0203E6;
    #1 check("x31_in_ready", bus.in_ready, 1'b1);
    step();
    $display("[TB] LDUR X31 + ADD X6,X31,X2 issued");
    check("x31_valid",     bus.out_valid, 1'b1);
    check("x31_rd",        bus.out_rd, 5'd6);
    check("x31_stall_cnt", stall_cnt, 16'd1);
    in_valid = 1'b0;
    step();

    // Backpressure: ORR held for 3 cycles, then EOR issues
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hAA020027;
    step();
    in_instr = 32'hCA020028;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", bus.in_ready, 1'b0);
      step();
      $display("[TB] backpressure cycle %0d", i);
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_rd",    bus.out_rd, 5'd7);
      check("bp_alu",   bus.out_alu_ctrl, 4'b0100);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", bus.in_ready, 1'b1);
    step();
    $display("[TB] EOR X8,X1,X2 issued");
    check("eor_rd",  bus.out_rd, 5'd8);
    check("eor_alu", bus.out_alu_ctrl, 4'b1001);

    // Flush with out_valid=1 and in_valid=1
    in_instr = 32'hCB020029;
    flush    = 1'b1;
    out_ready = 1'b0;
    #1 check("flush_in_ready", bus.in_ready, 1'b0);
    step();
    $display("[TB] flush");
    check("flush_valid",     bus.out_valid, 1'b0);
    check("flush_stall_cnt", stall_cnt, 16'd1);
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    check("post_flush_valid", bus.out_valid, 1'b0);

    // Back-to-back table: illegal, MOVZ, ADDI, STUR, CBZ, BL
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = v_instr[i];
      step();
      $display("[TB] instr %h issued", v_instr[i]);
      check("tbl_valid",   bus.out_valid, 1'b1);
      check("tbl_ctrl",    ctrl_of_dut(), v_ctrl[i]);
      check("tbl_alu",     bus.out_alu_ctrl, v_alu[i]);
      check("tbl_rd",      bus.out_rd, v_rd[i]);
      check("tbl_imm",     bus.out_imm, v_imm[i]);
      check("tbl_illegal", bus.out_illegal, v_ill[i]);
      if (v_instr[i] == 32'hD2E00020) begin
        check("movz32_illegal", bus_nh.out_illegal, 1'b1);
        check("movz32_imm",     bus_nh.out_imm, 64'd0);
        check("movz32_regwrite", bus_nh.out_regwrite, 1'b0);
      end
    end

    // Reset while a held instruction waits for out_ready
    out_ready = 1'b0;
    in_instr  = 32'h8B020023;
    step();
    check("hold_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid",    bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_rd",       bus.out_rd, 5'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h91001441;
    step();
    $display("[TB] ADDI after reset issued");
    check("postrst_valid", bus.out_valid, 1'b1);
    check("postrst_rd",    bus.out_rd, 5'd1);
    check("postrst_imm",   bus.out_imm, 64'd5);
    in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter HAZARD_EN, default 1, enables load-use bubble insertion (0 = never stall).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32: fetch-side handshake and instruction word.
REQ-006 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-008 SHALL have registered outputs out_reg2loc, out_uncondbranch, out_branch, out_memread, out_memtoreg, out_memwrite, out_alusrc, out_regwrite (1 each): datapath controls.
REQ-009 SHALL have registered outputs out_alu_ctrl 4, out_rn 5, out_rm 5, out_rd 5, out_imm DATA_W, out_illegal 1.
REQ-010 SHALL have output stall_cnt  16  saturating count of inserted hazard bubbles.

Function
REQ-011 Decode SHALL use full LEGv8 opcodes: B 000101, BL 100101 [31:26]; CBZ 10110100, CBNZ 10110101 [31:24]; ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000, EORI 1101001000 [31:22]; MOVZ 110100101 [31:23]; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000, LDUR 11111000010, STUR 11111000000 [31:21].
REQ-012 alu_ctrl: ADD/ADDI/LDUR/STUR 0010, SUB/SUBI 1010, AND/ANDI 0110, ORR/ORRI 0100, EOR/EORI 1001, MOVZ 1101, CBZ 0111, CBNZ 0001, B/BL 0000.
REQ-013 Controls: R-type regwrite=1 only; I-type/MOVZ alusrc=1 regwrite=1; LDUR memread=memtoreg=alusrc=regwrite=1; STUR reg2loc=alusrc=memwrite=1; CBZ/CBNZ reg2loc=branch=1; B/BL uncondbranch=1; every unlisted control 0 (no X outputs).
REQ-014 Fields: out_rn=[9:5], out_rm=[20:16], out_rd=[4:0] for every opcode; BL additionally forces out_rd=30 and regwrite=1.
REQ-015 Immediate: B/BL sign-extend [25:0]; CB sign-extend [23:5]; D-type sign-extend [20:12]; I-type zero-extend [21:10]; MOVZ zero-extend [20:5] shifted left 16*[22:21]; R-type 0; all to DATA_W.
REQ-016 Unmatched opcode, or MOVZ with [22:21]>=2 when DATA_W=32, SHALL set out_illegal=1, all controls 0, alu_ctrl 0000, out_imm 0.
REQ-017 Output register SHALL load when adv = !out_valid || out_ready; in_ready = adv && !flush && !hazard.
REQ-018 Transfer occurs when in_valid && in_ready; output fields capture decode of in_instr, out_valid<=1; if adv without transfer, out_valid<=0; if !adv, outputs hold stable.
REQ-019 Load tag: on each transfer, ld_tag<=in_instr[4:0] and ld_tag_v<=(instr is LDUR && Rt!=31); on adv without transfer, ld_tag_v<=0.
REQ-020 Sources: Rn for all except B/BL/MOVZ; Rm for R-type; Rt [4:0] for STUR/CBZ/CBNZ; register 31 never matches.
REQ-021 hazard = HAZARD_EN && ld_tag_v && in_valid && any source == ld_tag; at adv it yields exactly one bubble (out_valid<=0, ld_tag_v<=0), stall_cnt increments, instruction accepted next adv.
REQ-022 stall_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-023 flush SHALL take priority: out_valid<=0, ld_tag_v<=0, in_ready=0 that cycle, regardless of out_ready; stall_cnt unchanged.
REQ-024 Latency SHALL be one cycle from accepted input to out_valid with no hazard; full throughput 1 instr/cycle when out_ready=1.

Reset
REQ-025 rst_n low SHALL immediately clear out_valid, ld_tag_v, stall_cnt, all control outputs, out_alu_ctrl, out_rn/rm/rd, out_imm, out_illegal to 0; in_ready=0 while rst_n low.
REQ-026 Reset mid-handshake SHALL discard held instruction; first edge after deassertion accepts new input.

Verification
REQ-027 ADD X3,X1,X2 (0x8B020023), out_ready=1 -> next cycle out_valid=1, regwrite=1, alu_ctrl 0010, rn=1, rm=2, rd=3.
REQ-028 LDUR X5,[X1,#-8] (0xF85F8025) then ADD X6,X5,X2 back-to-back -> imm=all-ones-8 (-8), one bubble cycle, stall_cnt=1, ADD emitted cycle 3.
REQ-029 Same pair with HAZARD_EN=0, or load Rt=31 -> no bubble, stall_cnt=0.
REQ-030 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next instruction issues.
REQ-031 flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not accepted.
REQ-032 Word 0x00000000 -> out_illegal=1, all controls 0; MOVZ X0,#1,LSL#48 (0xD2E00020), DATA_W=64 -> imm 0x0001000000000000.
